// File: rtl/output_controler_if.sv
// output_controler_if: request/flit/grant/write bundle between input ports, the output controller and downstream
interface output_controler_if #(parameter int DATA_W = 8);
    logic [4:0]          req;
    logic [5*DATA_W-1:0] Data_in;
    logic                full;
    logic [4:0]          grant;
    logic [DATA_W-1:0]   Data_out;
    logic                write;
    modport master (input req, Data_in, full, output grant, Data_out, write);
    modport slave (output req, Data_in, full, input grant, Data_out, write);
endinterface

// File: rtl/output_controler.sv
// output_controler: arbitrates five input ports onto one output; OUTCTRL_RR_EN selects round-robin, else fixed priority
module output_controler #(parameter int DATA_W = 8) (
    input  logic                clk,
    input  logic                rst,
    output_controler_if.master  bus
);
    typedef enum logic {IDLE, SEND} state_t;
    state_t              state_q, state_d;
    logic [DATA_W-1:0]   hold_q, hold_d, data_out_q, data_out_d;
    logic [4:0]          grant_q, grant_d;
    logic [2:0]          last_q, last_d, win;
    logic                write_q, write_d;
    int                  j;
    // winner selection over the current requests; nearest candidate overwrites farther ones
    always_comb begin
        win = 3'd0;
        j   = 0;
        for (int k = 4; k >= 0; k--) begin
`ifdef OUTCTRL_RR_EN
            j = int'(last_q) + 1 + k;
            if (j >= 5) j = j - 5;
`else
            j = k;
`endif
            if (bus.req[j]) win = 3'(j);
        end
    end
    // next-state: capture and grant in IDLE, drain the held flit in SEND once downstream has room
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        last_d     = last_q;
        data_out_d = data_out_q;
        grant_d    = '0;
        write_d    = 1'b0;
        if (state_q == IDLE) begin
            if (|bus.req) begin
                hold_d  = bus.Data_in[win*DATA_W +: DATA_W];
                grant_d = 5'b00001 << win;
                last_d  = win;
                state_d = SEND;
            end
        end else if (!bus.full) begin
            data_out_d = hold_q;
            write_d    = 1'b1;
            state_d    = IDLE;
        end
    end
    // state registers with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            last_q     <= 3'd4;
            data_out_q <= '0;
            grant_q    <= '0;
            write_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            last_q     <= last_d;
            data_out_q <= data_out_d;
            grant_q    <= grant_d;
            write_q    <= write_d;
        end
    end
    assign bus.grant    = grant_q;
    assign bus.Data_out = data_out_q;
    assign bus.write    = write_q;
endmodule

// File: tb/tb_output_controler.sv
// tb_output_controler: scoreboard bench for output_controler
module tb_output_controler;
    localparam int W = 8;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    output_controler_if #(.DATA_W(W)) bus();
    output_controler #(.DATA_W(W)) dut (.clk(clk), .rst(rst), .bus(bus));
    int n_cmp = 0;
    int n_err = 0;
    logic [2:0]   last_m;
    logic [W-1:0] last_w;
    logic [W-1:0] q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] arb(input logic [4:0] r, input logic [2:0] l);
        int i;
`ifdef OUTCTRL_RR_EN
        for (int k = 1; k <= 5; k++) begin
            i = (int'(l) + k) % 5;
            if (r[i]) return 5'(1 << i);
        end
`else
        for (i = 0; i < 5; i++) if (r[i]) return 5'(1 << i);
`endif
        return 5'd0;
    endfunction

    function automatic int idx(input logic [4:0] g);
        for (int i = 0; i < 5; i++) if (g[i]) return i;
        return 0;
    endfunction

    task automatic wait_grant(output logic ok, output int lat);
        ok = 1'b0;
        lat = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.grant != 5'd0) begin
                ok = 1'b1;
                lat = c;
                break;
            end
        end
        if (!ok) check("grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic xact(input logic [4:0] r, input int nf, input logic drop);
        logic ok;
        int lat;
        logic [4:0] eg;
        bus.req = r;
        bus.full = (nf > 0);
        eg = arb(r, last_m);
        wait_grant(ok, lat);
        if (ok) begin
            check("grant", 32'(bus.grant), 32'(eg));
            check("grant_latency", lat, 0);
            check("write_clr", 32'(bus.write), 0);
            check("data_hold", 32'(bus.Data_out), 32'(last_w));
            last_m = 3'(idx(eg));
            q.push_back(bus.Data_in[idx(eg)*W +: W]);
        end
        if (drop) bus.req = 5'd0;
        for (int i = 0; i < nf; i++) begin
            @(negedge clk);
            check("bp_write", 32'(bus.write), 0);
            check("bp_grant", 32'(bus.grant), 0);
        end
        bus.full = 1'b0;
        @(negedge clk);
        check("write", 32'(bus.write), 1);
        check("one_grant", 32'(bus.grant), 0);
        if (q.size() > 0) begin
            last_w = q.pop_front();
            check("data", 32'(bus.Data_out), 32'(last_w));
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #3;
        check("rst_grant", 32'(bus.grant), 0);
        check("rst_write", 32'(bus.write), 0);
        check("rst_data", 32'(bus.Data_out), 0);
        @(negedge clk);
        rst = 1'b1;
        last_m = 3'd4;
        last_w = '0;
        q.delete();
    endtask

    initial begin
        logic ok;
        int lat;
        bus.req = 5'd0;
        bus.full = 1'b0;
        for (int i = 0; i < 5; i++) bus.Data_in[i*W +: W] = W'($urandom);
        do_reset();
        bus.full = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_write", 32'(bus.write), 0);
            check("idle_grant", 32'(bus.grant), 0);
        end
        bus.Data_in[2*W +: W] = 8'h6E;
        xact(5'b00100, 0, 1'b1);
        bus.Data_in[0 +: W] = 8'h07;
        xact(5'b00001, 4, 1'b1);
        for (int i = 0; i < 5; i++) bus.Data_in[i*W +: W] = W'($urandom);
        repeat (6) xact(5'b11111, 0, 1'b0);
        repeat (4) xact(5'b10010, 0, 1'b0);
        bus.req = 5'd0;
        @(negedge clk);
        do_reset();
        xact(5'b10001, 0, 1'b0);
        xact(5'b10001, 0, 1'b1);
        repeat (12) begin
            for (int i = 0; i < 5; i++) bus.Data_in[i*W +: W] = W'($urandom);
            xact(5'($urandom_range(1, 31)), $urandom_range(0, 2), 1'b1);
        end
        bus.req = 5'b00010;
        bus.full = 1'b1;
        bus.Data_in[W +: W] = 8'hA5;
        wait_grant(ok, lat);
        #2;
        do_reset();
        bus.req = 5'd0;
        bus.full = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("post_rst_write", 32'(bus.write), 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/output_controler.md
OUTPUT_CONTROLER -- requirements
Module: output_controler

Interface
REQ-001 Parameter DATA_W, default 8: flit width, {data[DATA_W-1:4], y_des[3:2], x_des[1:0]}, passed through unmodified.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 req  input  5  per-input-port request for this output; index 0 local, 1 north, 2 east, 3 south, 4 west; held by the requester until it sees its grant bit.
REQ-005 Data_in  input  5*DATA_W  flits from the input ports; slice i = Data_in[i*DATA_W +: DATA_W]; valid while req[i]=1.
REQ-006 full  input  1  downstream FIFO or link cannot accept a flit this cycle.
REQ-007 grant  output  5  one-hot, one-cycle acknowledge to the winning input port.
REQ-008 Data_out  output  DATA_W  flit to downstream, valid while write=1.
REQ-009 write  output  1  one-cycle write strobe to downstream.

Function
REQ-010 Two-state FSM: IDLE, SEND; all outputs registered.
REQ-011 IDLE, req==0: remain IDLE; grant=0, write=0.
REQ-012 IDLE, req!=0: pick winner w; capture hold<=Data_in slice w; grant<=one-hot(w) for the next cycle only; last<=w; go to SEND.
REQ-013 SEND, full=1: remain SEND; hold stable; write=0; grant=0.
REQ-014 SEND, full=0: Data_out<=hold; write<=1 for one cycle; go to IDLE.
REQ-015 Latency: req at edge N sampled -> grant high after edge N -> write high after edge N+1 when full=0; max throughput one flit per 2 cycles.
REQ-016 IDLE clears write to 0 in the cycle after a write pulse; a new arbitration can occur in that same cycle.
REQ-017 Data_out holds its last written value between writes.
REQ-018 Requests that change during SEND are ignored; they are sampled only in IDLE.
REQ-019 full is sampled only in SEND; full in IDLE has no effect.
REQ-020 Arbitration is combinational over req and last; at most one grant bit is set in any cycle.

Reset
REQ-021 rst=0 asynchronously forces state=IDLE, grant=0, write=0, Data_out=0, hold=0, last=4.
REQ-022 Reset during SEND discards the held flit; no write is issued for it after reset is released.
REQ-023 First active edge after rst deasserts behaves as IDLE.

Configuration
REQ-024 Macro OUTCTRL_RR_EN defined: round-robin arbitration; the search starts at (last+1) mod 5 and takes the first set req bit, wrapping 4->0.
REQ-025 OUTCTRL_RR_EN undefined: fixed priority, lowest set index wins; last is still updated but not used.

Verification
REQ-026 Reset: rst=0 mid-operation -> grant=0, write=0, Data_out=8'h00 immediately, without a clock edge.
REQ-027 Single request: req=5'b00100, slice 2=8'h6E, full=0 -> grant=5'b00100 for 1 cycle, then write=1 with Data_out=8'h6E for 1 cycle.
REQ-028 Backpressure: req=5'b00001, flit 8'h07, full=1 for 4 cycles then 0 -> grant once; write stays 0 while full=1; write=1 with Data_out=8'h07 on the first cycle after full drops.
REQ-029 Round-robin, RR_EN defined: req=5'b11111 held, full=0 -> grants in order 00001, 00010, 00100, 01000, 10000, 00001, one grant every 2 cycles.
REQ-030 Fixed priority, RR_EN undefined: req=5'b10010 held -> every grant is 5'b00010; port 4 is never granted.
REQ-031 Wrap: RR_EN defined, last=4 and req=5'b10001 -> port 0 is granted; after that, port 4 is granted next.
